// File: rtl/updown_count_if.sv
// Control/datapath bundle between the up/down count controller, its driver and the
// external adder/subtractor.
interface updown_count_if #(parameter int WIDTH = 4);
    logic             en;
    logic             start;
    logic             stop;
    logic             dir_in;
    logic             bounce;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sel;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             wrap;
    logic             turn;

    modport master (
        output en, start, stop, dir_in, bounce, load, load_val, limit, sum_in,
        input  op_a, op_b, op_sel, q, busy, wrap, turn
    );

    modport slave (
        input  en, start, stop, dir_in, bounce, load, load_val, limit, sum_in,
        output op_a, op_b, op_sel, q, busy, wrap, turn
    );
endinterface

// File: rtl/updown_count_ctrl.sv
// Sequential control for an external 4-bit adder/subtractor: count register, run/stop FSM,
// programmable upper limit, wrap or bounce at the ends, single-cycle wrap/turn pulses.
module updown_count_ctrl #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    updown_count_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] UP   = 2'd1;
    localparam logic [1:0] DOWN = 2'd2;

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH:0]   STEP_W1 = (WIDTH+1)'(STEP);

    logic [1:0]       state;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic             turn;
    logic             up_term;
    logic             dn_term;

    // Extra bit so q + STEP cannot overflow and q > limit also reads as terminal.
    assign up_term = ({1'b0, q} + STEP_W1) > {1'b0, bus.limit};
    assign dn_term = q < STEP_W;

    assign bus.op_a   = q;
    assign bus.op_b   = STEP_W;
    assign bus.op_sel = (state == DOWN);
    assign bus.q      = q;
    assign bus.busy   = (state == UP) || (state == DOWN);
    assign bus.wrap   = wrap;
    assign bus.turn   = turn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            wrap  <= 1'b0;
            turn  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            turn <= 1'b0;
            if (bus.en) begin
                if (bus.load) begin
                    q <= bus.load_val;
                end else if (bus.stop) begin
                    state <= IDLE;
                end else if (state == IDLE) begin
                    if (bus.start)
                        state <= bus.dir_in ? DOWN : UP;
                end else if ((state == UP && up_term) || (state == DOWN && dn_term)) begin
                    // At an end: sum_in is not trusted here, the end value is chosen locally.
                    if (bus.bounce) begin
                        state <= (state == UP) ? DOWN : UP;
                        turn  <= 1'b1;
                    end else begin
                        q    <= (state == UP) ? '0 : bus.limit;
                        wrap <= 1'b1;
                    end
                end else begin
                    q <= bus.sum_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_updown_count_ctrl.sv
// Randomised and directed bench for updown_count_ctrl against an integer-level reference model.
module tb_updown_count_ctrl;
    localparam int W    = 4;
    localparam int STEP = 1;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    updown_count_if #(.WIDTH(W)) bus ();

    // Behavioural adder/subtractor in place of the external datapath.
    assign bus.sum_in = bus.op_sel ? W'(bus.op_a - bus.op_b) : W'(bus.op_a + bus.op_b);

    updown_count_ctrl #(.WIDTH(W), .STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: integer count, running flag and direction as +1/-1.
    int m_q    = 0;
    bit m_run  = 0;
    int m_dir  = 1;
    bit m_wrap = 0;
    bit m_turn = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_edge();
        int lim;
        lim    = int'(bus.limit);
        m_wrap = 0;
        m_turn = 0;
        if (!rst_n) begin
            m_q = 0; m_run = 0; m_dir = 1;
        end else if (bus.en) begin
            if (bus.load) m_q = int'(bus.load_val);
            else if (bus.stop) m_run = 0;
            else if (!m_run) begin
                if (bus.start) begin m_run = 1; m_dir = bus.dir_in ? -1 : 1; end
            end else if ((m_dir > 0 && m_q + STEP > lim) || (m_dir < 0 && m_q < STEP)) begin
                if (bus.bounce) begin m_dir = -m_dir; m_turn = 1; end
                else begin m_q = (m_dir > 0) ? 0 : lim; m_wrap = 1; end
            end else begin
                m_q = (m_q + m_dir * STEP) & MASK;
            end
        end
    endtask

    task automatic check_outs();
        chk("q",      int'(bus.q),      m_q);
        chk("busy",   int'(bus.busy),   int'(m_run));
        chk("wrap",   int'(bus.wrap),   int'(m_wrap));
        chk("turn",   int'(bus.turn),   int'(m_turn));
        chk("op_sel", int'(bus.op_sel), (m_run && m_dir < 0) ? 1 : 0);
        chk("op_a",   int'(bus.op_a),   m_q);
        chk("op_b",   int'(bus.op_b),   STEP);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic quiet();
        bus.load = 0; bus.stop = 0; bus.start = 0;
    endtask

    initial begin
        rst_n = 0; bus.en = 1; quiet(); bus.dir_in = 0; bus.bounce = 0;
        bus.load_val = '0; bus.limit = 4'd15;
        @(negedge clk);
        cyc(); cyc();
        rst_n = 1;

        // Reset mid-count at q=7.
        bus.start = 1; cyc(); quiet();
        repeat (7) cyc();
        chk("pre_reset_q", int'(bus.q), 7);
        rst_n = 0; cyc(); cyc(); rst_n = 1;
        chk("reset_q", int'(bus.q), 0);
        chk("reset_busy", int'(bus.busy), 0);

        // Wrap up through full range.
        bus.limit = 4'd15; bus.bounce = 0; bus.dir_in = 0;
        bus.start = 1; cyc(); quiet();
        repeat (17) cyc();

        // Bounce between 0 and 5.
        bus.stop = 1; cyc(); quiet();
        bus.load_val = 4'd0; bus.load = 1; cyc(); quiet();
        bus.limit = 4'd5; bus.bounce = 1; bus.start = 1; cyc(); quiet();
        repeat (14) cyc();

        // Wrap down from 2 with limit 9.
        bus.stop = 1; cyc(); quiet();
        bus.limit = 4'd9; bus.bounce = 0; bus.load_val = 4'd2; bus.load = 1; cyc(); quiet();
        bus.dir_in = 1; bus.start = 1; cyc(); quiet();
        repeat (4) cyc();

        // Priority: load beats stop and start while running up.
        bus.stop = 1; cyc(); quiet();
        bus.limit = 4'd15; bus.dir_in = 0; bus.start = 1; cyc(); quiet();
        cyc();
        bus.load_val = 4'd11; bus.load = 1; bus.stop = 1; bus.start = 1; cyc(); quiet();
        chk("prio_q", int'(bus.q), 11);
        chk("prio_busy", int'(bus.busy), 1);
        bus.stop = 1; cyc(); quiet();
        chk("stop_busy", int'(bus.busy), 0);

        // Hold with en=0 in DOWN at q=6.
        bus.load_val = 4'd6; bus.load = 1; cyc(); quiet();
        bus.dir_in = 1; bus.start = 1; cyc(); quiet();
        bus.en = 0; repeat (4) cyc();
        bus.en = 1; cyc();
        chk("resume_q", int'(bus.q), 5);

        // limit==0 in both modes.
        bus.stop = 1; cyc(); quiet();
        bus.load_val = 4'd0; bus.load = 1; cyc(); quiet();
        bus.limit = 4'd0; bus.dir_in = 0; bus.start = 1; cyc(); quiet();
        repeat (4) cyc();
        bus.bounce = 1; repeat (4) cyc();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            bus.en       = ($urandom_range(0, 9) != 0);
            bus.load     = ($urandom_range(0, 19) == 0);
            bus.stop     = ($urandom_range(0, 29) == 0);
            bus.start    = ($urandom_range(0, 4) == 0);
            bus.dir_in   = 1'($urandom);
            bus.load_val = W'($urandom);
            if ($urandom_range(0, 15) == 0) bus.bounce = 1'($urandom);
            if ($urandom_range(0, 19) == 0) bus.limit  = W'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
